sha256_job_loader: RTL and testbench
====================================

# sha256_job_loader

Host-side counterpart to the SHA-256 hasher on the shared word-addressed memory. It accepts a message as a stream of 32-bit words, writes them into memory, and pulses the hasher's start. It then waits for the hasher's done, reads the 8-word digest back from memory and streams it out. It owns the memory port only while loading or unloading; an external mux gives the port to the hasher whenever `mem_own` is low.

## Interface
- `NUM_WORDS`, default 20: message words per job; legal range 1..64.
- `DIGEST_WORDS`, default 8: digest words read back per job; legal range 1..16.
- `clk` input 1: clock; also the memory clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `job_message_addr` input 16: memory base address for message words.
- `job_output_addr` input 16: memory base address of the hasher's digest.
- `in_valid` input 1: message word valid.
- `in_data` input 32: message word.
- `in_ready` output 1: loader accepts a word this cycle.
- `out_valid` output 1: digest word valid.
- `out_data` output 32: digest word, word 0 first.
- `out_last` output 1: marks the final digest word.
- `out_ready` input 1: consumer accepts the digest word.
- `hash_start` output 1: one-cycle start pulse to the hasher.
- `hash_done` input 1: done from the hasher.
- `mem_own` output 1: loader drives the memory port.
- `mem_we` output 1: memory write enable.
- `mem_addr` output 16: memory address.
- `mem_write_data` output 32: memory write data.
- `mem_read_data` input 32: memory read data; valid the cycle after a read address is presented.
- `busy` output 1: a job is in progress (any state except IDLE).

## Operation
- States: IDLE, LOAD, START, WAIT, RADDR, RDATA, OUT.
- Reset (`reset_n` low at a clock edge):
  - state goes to IDLE and both counters clear;
  - every output is 0: `in_ready`, `out_valid`, `out_data`, `out_last`, `hash_start`, `mem_own`, `mem_we`, `mem_addr`, `mem_write_data`, `busy`.
  - `in_ready` rises the first cycle after `reset_n` is sampled high.
- Reset mid-job: the partial job is dropped with no start pulse and no output. The hasher is not reset by this block.
- IDLE:
  - `in_ready`=1.
  - The first accepted word (`in_valid` & `in_ready`) latches both job addresses, sets word index i=0 and moves to LOAD.
  - That word is written at `msg+0`.
- LOAD:
  - Each accepted word i is written at `msg+i`.
  - `mem_addr`, `mem_we` and `mem_write_data` are registered: the write appears the cycle after the handshake.
  - `mem_own`=1 from the first write through the last write cycle.
  - `in_ready` drops in the cycle after word NUM_WORDS-1 is accepted.
  - If NUM_WORDS=1, the IDLE handshake word is the only one and LOAD is one cycle.
  - `in_valid` gaps are allowed; `mem_we`=0 in gap cycles.
- START: entered the cycle after the last write cycle. `hash_start`=1 for exactly one cycle, `mem_own`=0.
- WAIT:
  - `mem_own`=0 and `mem_we`=0.
  - Leaves on `hash_done`=1, even if it is already high the cycle after START.
  - `hash_done` is ignored in every other state.
- Digest read loop, word index j from 0 to DIGEST_WORDS-1:
  - RADDR: `mem_own`=1, `mem_we`=0, `mem_addr=out+j`.
  - RDATA: `mem_read_data` is captured into `out_data`; `out_last` is set when j=DIGEST_WORDS-1.
  - OUT: `out_valid`=1 and `out_data` held stable until `out_ready`.
  - On handshake: if not the last word, go to RADDR with j+1; if the last word, go to IDLE.
  - `mem_own` stays 1 from RADDR of word 0 until the return to IDLE.
- Address arithmetic is 16-bit modulo 2^16: a base of 16'hFFFF wraps to 16'h0000.
- Job addresses are not re-sampled mid-job.
- `in_valid` is ignored outside IDLE and LOAD; `in_ready` is 0 there.

## Timing
- Last word accepted at cycle T:
  - write at T+1;
  - `hash_start` at T+2;
  - `mem_own` falls at T+2.
- `hash_done` sampled high at cycle D:
  - address of digest word 0 at D+1;
  - data captured at the D+2 edge;
  - `out_valid` at D+3.
- Each further digest word takes 3 cycles from the previous handshake with `out_ready` held high, so 8 words finish no earlier than D+3+21.
- Back-to-back input: `in_ready` stays 1 continuously, giving NUM_WORDS writes on consecutive cycles.
- A new job may start the cycle after IDLE is re-entered (`in_ready`=1 then).

## Test plan
- Reset, then NUM_WORDS=20 words 32'h00000000..32'h00000013 on consecutive cycles with msg=16'h0000 -> 20 writes on consecutive cycles to addresses 0..19 with matching data, then one `hash_start` pulse 2 cycles after the last accept.
- Memory model preloads 16'h0080..16'h0087 with 32'hA0000000+j; `hash_done` is asserted 50 cycles after start -> `out_data` A0000000..A0000007 in order, `out_last` only on A0000007, first `out_valid` 3 cycles after done.
- `out_ready` low for 5 cycles on word 3 -> `out_valid` and `out_data` stay stable throughout; no extra memory read is issued; word 4 follows normally.
- msg=16'hFFFE with 4 words (NUM_WORDS=4) -> writes go to FFFE, FFFF, 0000, 0001.
- `hash_done` pulsed during LOAD and during IDLE -> ignored; the unload starts only after a done seen in WAIT.
- `reset_n` low for 1 cycle during LOAD (after 7 words), then a full job -> no `hash_start` for the aborted job; all outputs 0 in the reset cycle; the new job writes from index 0.

Source files
------------

// File: rtl/sha256_job_loader.sv
// ---------------------------------------------------------------------------
// sha256_job_loader
//
// Host-side companion to the SHA-256 hasher sharing one word-addressed
// memory. A job is: accept NUM_WORDS message words and write them to
// memory starting at job_message_addr, pulse hash_start, wait for hash_done,
// read DIGEST_WORDS words back from job_output_addr and stream them out.
// The loader drives the memory port only while mem_own is high; an external
// mux hands the port to the hasher otherwise.
//
// Ports
//   clk, reset_n         : clock (also the memory clock), sync active-low reset
//   job_message_addr     : base address for message words (latched per job)
//   job_output_addr      : base address of the digest (latched per job)
//   in_valid/in_ready    : message word input stream, in_data payload
//   out_valid/out_ready  : digest output stream, out_data/out_last payload
//   hash_start           : one-cycle start pulse to the hasher
//   hash_done            : done from the hasher, only looked at in WAIT
//   mem_own              : loader owns the memory port
//   mem_we/mem_addr/
//   mem_write_data       : registered memory write / address port
//   mem_read_data        : read data, valid the cycle after the address
//   busy                 : a job is in progress
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer holding valid keeps its payload stable until
// that edge; ready may be low for any number of cycles.
//
// All outputs are registered so the reset cycle shows every output at 0 and
// in_ready only rises once reset_n has been sampled high.
// ---------------------------------------------------------------------------
module sha256_job_loader #(
  parameter int NUM_WORDS    = 20,
  parameter int DIGEST_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] job_message_addr,
  input  logic [15:0] job_output_addr,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_own,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_RADDR,
    S_RDATA,
    S_OUT
  } state_t;

  localparam logic [6:0] LAST_W = 7'(NUM_WORDS - 1);
  localparam logic [4:0] LAST_D = 5'(DIGEST_WORDS - 1);

  state_t      r_state, w_state_next;

  logic        r_in_ready,  w_in_ready;
  logic        r_out_valid, w_out_valid;
  logic [31:0] r_out_data,  w_out_data;
  logic        r_out_last,  w_out_last;
  logic        r_hash_start, w_hash_start;
  logic        r_mem_own,   w_mem_own;
  logic        r_mem_we,    w_mem_we;
  logic [15:0] r_mem_addr,  w_mem_addr;
  logic [31:0] r_mem_wdata, w_mem_wdata;
  logic        r_busy,      w_busy;
  logic [15:0] r_msg_base,  w_msg_base;
  logic [15:0] r_out_base,  w_out_base;
  // r_widx counts accepted message words (0..NUM_WORDS)
  logic [6:0]  r_widx,      w_widx;
  // r_ridx is the digest word currently being read / presented
  logic [4:0]  r_ridx,      w_ridx;

  logic        w_accept;

  // in_ready is only ever high in IDLE/LOAD, so no extra state gating here
  assign w_accept = in_valid && r_in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = r_in_ready;
    w_out_valid  = r_out_valid;
    w_out_data   = r_out_data;
    w_out_last   = r_out_last;
    w_hash_start = 1'b0;
    w_mem_own    = r_mem_own;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_msg_base   = r_msg_base;
    w_out_base   = r_out_base;
    w_widx       = r_widx;
    w_ridx       = r_ridx;

    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_mem_own  = 1'b0;
        w_ridx     = '0;
        if (w_accept) begin
          // Addresses are captured once here and held for the whole job
          w_msg_base   = job_message_addr;
          w_out_base   = job_output_addr;
          w_mem_own    = 1'b1;
          w_mem_we     = 1'b1;
          w_mem_addr   = job_message_addr;
          w_mem_wdata  = in_data;
          w_widx       = 7'd1;
          w_in_ready   = (NUM_WORDS != 1);
          w_state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_msg_base + {9'd0, r_widx};
          w_mem_wdata = in_data;
          w_widx      = r_widx + 7'd1;
          if (r_widx == LAST_W) w_in_ready = 1'b0;
        end else if (!r_in_ready) begin
          // This cycle carries the final write; release the port next
          w_state_next = S_START;
          w_mem_own    = 1'b0;
          w_hash_start = 1'b1;
        end
      end

      S_START: begin
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (hash_done) begin
          w_state_next = S_RADDR;
          w_mem_own    = 1'b1;
          w_mem_addr   = r_out_base + {11'd0, r_ridx};
        end
      end

      S_RADDR: begin
        w_state_next = S_RDATA;
      end

      S_RDATA: begin
        w_out_data   = mem_read_data;
        w_out_last   = (r_ridx == LAST_D);
        w_out_valid  = 1'b1;
        w_state_next = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          if (r_out_last) begin
            w_state_next = S_IDLE;
            w_out_last   = 1'b0;
            w_out_data   = '0;
            w_mem_own    = 1'b0;
            w_in_ready   = 1'b1;
          end else begin
            w_ridx       = r_ridx + 5'd1;
            w_mem_addr   = r_out_base + {11'd0, r_ridx + 5'd1};
            w_state_next = S_RADDR;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_busy = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_hash_start <= 1'b0;
      r_mem_own    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_msg_base   <= '0;
      r_out_base   <= '0;
      r_widx       <= '0;
      r_ridx       <= '0;
    end else begin
      r_in_ready   <= w_in_ready;
      r_out_valid  <= w_out_valid;
      r_out_data   <= w_out_data;
      r_out_last   <= w_out_last;
      r_hash_start <= w_hash_start;
      r_mem_own    <= w_mem_own;
      r_mem_we     <= w_mem_we;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_busy       <= w_busy;
      r_msg_base   <= w_msg_base;
      r_out_base   <= w_out_base;
      r_widx       <= w_widx;
      r_ridx       <= w_ridx;
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign hash_start     = r_hash_start;
  assign mem_own        = r_mem_own;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign busy           = r_busy;

endmodule

// File: tb/tb_sha256_job_loader.sv
// ---------------------------------------------------------------------------
// tb_sha256_job_loader
//
// Directed bench. Main DUT uses NUM_WORDS=20, DIGEST_WORDS=8 and a memory
// model whose 16'h0080..16'h0087 region reads back 32'hA0000000+j. A second
// DUT with NUM_WORDS=4 exercises 16-bit address wrap from 16'hFFFE.
// Outputs are sampled 1 time unit after the rising edge; inputs are driven
// at the same point so they are stable by the next edge.
// ---------------------------------------------------------------------------
module tb_sha256_job_loader;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic [15:0] job_message_addr, job_output_addr;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic        hash_start, hash_done;
  logic        mem_own, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic        busy;

  // ---------------- wrap DUT signals ----------------
  logic [15:0] msg4, outa4;
  logic        in_valid4, in_ready4;
  logic [31:0] in_data4;
  logic        out_valid4, out_last4, out_ready4;
  logic [31:0] out_data4;
  logic        hash_start4, hash_done4;
  logic        mem_own4, mem_we4;
  logic [15:0] mem_addr4;
  logic [31:0] mem_wdata4, mem_rdata4;
  logic        busy4;

  sha256_job_loader #(.NUM_WORDS(20), .DIGEST_WORDS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_message_addr(job_message_addr), .job_output_addr(job_output_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .hash_start(hash_start), .hash_done(hash_done),
    .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  sha256_job_loader #(.NUM_WORDS(4), .DIGEST_WORDS(8)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .job_message_addr(msg4), .job_output_addr(outa4),
    .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_last(out_last4),
    .out_ready(out_ready4), .hash_start(hash_start4), .hash_done(hash_done4),
    .mem_own(mem_own4), .mem_we(mem_we4), .mem_addr(mem_addr4),
    .mem_write_data(mem_wdata4), .mem_read_data(mem_rdata4),
    .busy(busy4)
  );

  // ---------------- memory model + monitors ----------------
  logic [31:0] mem [0:65535];
  int hs_cnt = 0;
  int rd_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (a >= 16'h0080 && a <= 16'h0087) return 32'hA000_0000 + {29'd0, a[2:0]};
    return mem[a];
  endfunction

  always @(posedge clk) begin
    if (mem_own && mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem_rd(mem_addr);
    if (hash_start) hs_cnt <= hs_cnt + 1;
    // address-phase and data-phase cycles of a digest read
    if (busy && mem_own && !mem_we && !in_ready && !out_valid) rd_cnt <= rd_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_job(input logic [15:0] msg, input logic [31:0] dbase,
                          input int n, input int gap_at, input int done_at);
    job_message_addr = msg;
    job_output_addr  = 16'h0080;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        tick();
        check("gap_no_write", {61'd0, mem_own, mem_we, in_ready}, 64'b101);
      end
      in_valid  = 1'b1;
      in_data   = dbase + 32'(i);
      hash_done = (i == done_at);
      tick();
      hash_done = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!hash_start && n < 10) begin
      tick();
      n++;
    end
    check("start_seen", {63'd0, hash_start}, 64'd1);
    tick();
  endtask

  task automatic drain(input int stall_word);
    int          n;
    logic [31:0] e;
    logic        stable;
    for (int w = 0; w < 8; w++) begin
      e = exp_q.pop_front();
      n = 0;
      while (!out_valid && n < 8) begin
        tick();
        n++;
      end
      check("digest_word", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, (w == 7), e});
      if (w > 0) check("word_cadence", 64'(n), 64'd2);
      if (w == stall_word) begin
        out_ready = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (!out_valid || out_data !== e) stable = 1'b0;
        end
        check("stall_stable", {63'd0, stable}, 64'd1);
        out_ready = 1'b1;
      end
      tick();
    end
    check("back_to_idle", {60'd0, busy, in_ready, mem_own, out_valid}, 64'b0100);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] wrap_addr [4];
  int          rd_base, hs_base, bad;

  initial begin
    wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
    wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
    reset_n = 1'b0;
    job_message_addr = 16'h0000; job_output_addr = 16'h0080;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; hash_done = 1'b0;
    msg4 = 16'hFFFE; outa4 = 16'h0000; in_valid4 = 1'b0; in_data4 = '0;
    out_ready4 = 1'b1; hash_done4 = 1'b0; mem_rdata4 = '0;

    // reset
    tick(); tick();
    check("reset_ctrl", {41'd0, in_ready, out_valid, out_last, hash_start, mem_own, mem_we, busy, mem_addr}, 64'd0);
    check("reset_data", {out_data, mem_write_data}, 64'd0);
    check("reset_dut4", {57'd0, in_ready4, out_valid4, hash_start4, mem_own4, mem_we4, busy4, out_last4}, 64'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_reset", {62'd0, in_ready, in_ready4}, 64'b11);

    // address wrap on the 4-word DUT
    for (int i = 0; i < 4; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 32'h5000_0000 + 32'(i);
      tick();
      check("wrap_write", {14'd0, mem_own4, mem_we4, mem_addr4, mem_wdata4},
            {14'd0, 1'b1, 1'b1, wrap_addr[i], 32'h5000_0000 + 32'(i)});
    end
    in_valid4 = 1'b0;
    tick();
    check("wrap_start", {62'd0, hash_start4, mem_own4}, 64'b10);

    // main job: 20 back-to-back words at msg=0
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      check("load_write", {13'd0, (i != 19), mem_own, mem_we, 16'(mem_addr), mem_write_data},
            {13'd0, (i != 19), 1'b1, 1'b1, 16'(i), 32'(i)});
    end
    in_valid = 1'b0;
    tick();
    check("start_pulse", {60'd0, hash_start, mem_own, mem_we, busy}, 64'b1001);
    tick();
    check("start_one_cycle", {61'd0, hash_start, mem_own, busy}, 64'b001);
    for (int k = 0; k < 48; k++) tick();
    check("wait_idle", {60'd0, out_valid, mem_own, mem_we, busy}, 64'b0001);

    for (int j = 0; j < 8; j++) exp_q.push_back(32'hA000_0000 + 32'(j));
    rd_base = rd_cnt;
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    check("raddr_d1", {46'd0, mem_own, mem_we, mem_addr}, {46'd0, 1'b1, 1'b0, 16'h0080});
    tick();
    check("no_valid_d2", {63'd0, out_valid}, 64'd0);
    tick();
    check("valid_d3", {63'd0, out_valid}, 64'd1);
    drain(3);
    check("read_cycles", 64'(rd_cnt - rd_base), 64'd16);

    // done in IDLE and in LOAD must be ignored
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    tick();
    check("done_in_idle", {61'd0, busy, mem_own, out_valid}, 64'd0);
    load_job(16'h0100, 32'hB000_0000, 20, 10, 5);
    wait_start();
    for (int k = 0; k < 10; k++) tick();
    check("done_in_load", {61'd0, out_valid, mem_own, busy}, 64'b001);
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[16'(16'h0100 + i)] !== 32'hB000_0000 + 32'(i)) bad++;
    check("job2_mem", 64'(bad), 64'd0);
    for (int j = 0; j < 8; j++) exp_q.push_back(32'hA000_0000 + 32'(j));
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    drain(-1);

    // reset after 7 words of a load, then a fresh job at the same base
    hs_base = hs_cnt;
    load_job(16'h0200, 32'hC000_0000, 7, -1, -1);
    reset_n = 1'b0;
    tick();
    check("midreset_ctrl", {41'd0, in_ready, out_valid, out_last, hash_start, mem_own, mem_we, busy, mem_addr}, 64'd0);
    check("midreset_data", {out_data, mem_write_data}, 64'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("no_start_aborted", 64'(hs_cnt - hs_base), 64'd0);
    job_message_addr = 16'h0200;
    in_valid = 1'b1;
    in_data  = 32'hD000_0000;
    tick();
    check("restart_first", {14'd0, mem_own, mem_we, mem_addr, mem_write_data},
          {14'd0, 1'b1, 1'b1, 16'h0200, 32'hD000_0000});
    load_job(16'h0200, 32'hD000_0001, 19, -1, -1);
    wait_start();
    check("one_start_job3", 64'(hs_cnt - hs_base), 64'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) if (mem[16'(16'h0200 + i)] !== 32'hD000_0000 + 32'(i)) bad++;
    check("job3_mem", 64'(bad), 64'd0);
    for (int j = 0; j < 8; j++) exp_q.push_back(32'hA000_0000 + 32'(j));
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    drain(-1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
